// File: rtl/board_defs_pkg.sv
// Shared board geometry, cell/row sentinels, scan FSM states and the tag layout.
package board_defs;

  localparam int unsigned BOARD_W     = 10;
  localparam int unsigned BOARD_H     = 25;
  localparam int unsigned BOARD_CELLS = BOARD_W * BOARD_H;

  localparam logic [5:0] CELL_EMPTY = 6'd0;
  localparam logic [4:0] NO_ROW     = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  // Tag travelling with each read: {valid, last_col, row}
  localparam int unsigned TAG_W = 7;

endpackage

// File: rtl/scan_tag_pipe.sv
// Delay line carrying {valid, last_col, row} alongside an in-flight RAM read.
module scan_tag_pipe
  import board_defs::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out
);

  logic [TAG_W-1:0] stage [DEPTH];

  // Shift tags one stage per cycle; flush drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/board_row_scan.sv
// Sweeps the board RAM once per enable and reports which rows are completely filled.
module board_row_scan
  import board_defs::*;
#(
  parameter int unsigned WIDTH        = BOARD_W,
  parameter int unsigned HEIGHT       = BOARD_H,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [7:0]        ram_addr,
  output logic              wren,
  input  logic [5:0]        ram_q,
  output logic [HEIGHT-1:0] row_full,
  output logic [4:0]        full_count,
  output logic [4:0]        first_full,
  output logic              complete
);

  localparam int unsigned CELLS     = WIDTH * HEIGHT;
  localparam int unsigned DEPTH     = 1 + READ_LATENCY;
  localparam logic [7:0]  LAST_ADDR = 8'(CELLS - 1);
  localparam logic [7:0]  LAST_COL  = 8'(WIDTH - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(HEIGHT - 1);

  scan_state_t      state;
  logic [7:0]       col_cnt;
  logic [4:0]       row_cnt;
  logic [7:0]       col_next;
  logic [4:0]       row_next;
  logic             acc;
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_out;
  logic             tag_valid;
  logic             tag_last;
  logic [4:0]       tag_row;
  logic             abort;
  logic             sampling;
  logic             row_result;
  logic             done_hit;

  assign wren = 1'b0;

  assign tag_valid  = tag_out[6];
  assign tag_last   = tag_out[5];
  assign tag_row    = tag_out[4:0];
  assign abort      = !enable && (state == ST_ISSUE || state == ST_DRAIN);
  assign sampling   = enable && tag_valid && (state == ST_ISSUE || state == ST_DRAIN);
  assign row_result = acc && (ram_q != CELL_EMPTY);
  assign done_hit   = sampling && tag_last && (tag_row == LAST_ROW);

  // Next column/row, and the tag of the address being loaded into ram_addr this edge.
  // Stage 0 of the tag pipe therefore lines up with ram_addr itself.
  always_comb begin
    col_next = col_cnt + 8'd1;
    row_next = row_cnt;
    if (col_cnt == LAST_COL) begin
      col_next = '0;
      row_next = row_cnt + 5'd1;
    end
    tag_in = '0;
    if (enable) begin
      if (state == ST_IDLE)
        tag_in = {1'b1, (WIDTH == 1), 5'd0};
      else if (state == ST_ISSUE && ram_addr != LAST_ADDR)
        tag_in = {1'b1, (col_next == LAST_COL), row_next};
    end
  end

  scan_tag_pipe #(.DEPTH(DEPTH)) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (abort),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Scan FSM: address issue, sample accumulation and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ram_addr   <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      acc        <= 1'b1;
      row_full   <= '0;
      full_count <= '0;
      first_full <= NO_ROW;
      complete   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ram_addr <= '0;
          col_cnt  <= '0;
          row_cnt  <= '0;
          if (enable) begin
            state      <= ST_ISSUE;
            acc        <= 1'b1;
            row_full   <= '0;
            full_count <= '0;
            first_full <= NO_ROW;
            complete   <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (!enable) begin
            state    <= ST_IDLE;
            ram_addr <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
          end else if (ram_addr == LAST_ADDR) begin
            state    <= ST_DRAIN;
            ram_addr <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
          end else begin
            ram_addr <= ram_addr + 8'd1;
            col_cnt  <= col_next;
            row_cnt  <= row_next;
          end
        end
        ST_DRAIN: begin
          ram_addr <= '0;
          if (!enable) begin
            state <= ST_IDLE;
          end else if (done_hit) begin
            state    <= ST_DONE;
            complete <= 1'b1;
          end
        end
        default: begin
          ram_addr <= '0;
          if (!enable) begin
            state    <= ST_IDLE;
            complete <= 1'b0;
          end
        end
      endcase

      // Row accumulation; the accumulator re-arms after each row's last column.
      if (sampling) begin
        if (tag_last) begin
          acc               <= 1'b1;
          row_full[tag_row] <= row_result;
          full_count        <= full_count + {4'd0, row_result};
          if (row_result && first_full == NO_ROW) first_full <= tag_row;
        end else begin
          acc <= row_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_board_row_scan.sv
// Directed bench for board_row_scan: two instances (read latency 1 and 3) on one board image.
module tb_board_row_scan;
  import board_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [5:0]  board [0:BOARD_CELLS-1];

  logic [7:0]  addr1, addr3;
  logic        wren1, wren3;
  logic [5:0]  q1, q3;
  logic [24:0] rf1, rf3;
  logic [4:0]  fc1, fc3, ff1, ff3;
  logic        cp1, cp3;

  logic [7:0]  ap1;
  logic [7:0]  ap3 [3];
  logic        wren_seen = 1'b0;

  int errors = 0;
  int checks = 0;
  int addr_bad = 0;
  int lat1, lat3, seen;

  always #5 clk = ~clk;

  board_row_scan #(.WIDTH(10), .HEIGHT(25), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .ram_addr(addr1), .wren(wren1),
    .ram_q(q1), .row_full(rf1), .full_count(fc1), .first_full(ff1), .complete(cp1)
  );

  board_row_scan #(.WIDTH(10), .HEIGHT(25), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .ram_addr(addr3), .wren(wren3),
    .ram_q(q3), .row_full(rf3), .full_count(fc3), .first_full(ff3), .complete(cp3)
  );

  // RAM models: address registered READ_LATENCY times, then read combinationally.
  always @(posedge clk) begin
    ap1    <= addr1;
    ap3[0] <= addr3;
    ap3[1] <= ap3[0];
    ap3[2] <= ap3[1];
    if (wren1 !== 1'b0 || wren3 !== 1'b0) wren_seen <= 1'b1;
  end
  assign q1 = (ap1    < 8'd250) ? board[ap1]    : 6'd0;
  assign q3 = (ap3[2] < 8'd250) ? board[ap3[2]] : 6'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 250; i++) board[i] = 6'd0;
  endtask

  task automatic fill_row(input int r, input logic [5:0] code);
    for (int c = 0; c < 10; c++) board[r*10 + c] = code;
  endtask

  // Raise enable, count edges from E0 until both instances report complete (bounded).
  task automatic run_sweep(output int l1, output int l3);
    l1 = -1;
    l3 = -1;
    @(negedge clk) enable = 1'b1;
    for (int n = 1; n <= 400 && (l1 < 0 || l3 < 0); n++) begin
      @(posedge clk);
      #1;
      if (n - 1 < 250) begin
        if (addr1 !== 8'(n - 1)) addr_bad++;
        if (addr3 !== 8'(n - 1)) addr_bad++;
      end
      if (cp1 === 1'b1 && l1 < 0) l1 = n - 1;
      if (cp3 === 1'b1 && l3 < 0) l3 = n - 1;
    end
  endtask

  task automatic end_sweep(input string tag, input logic [24:0] rf_want);
    @(negedge clk) enable = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_complete_drop"}, {31'd0, cp1}, 32'd0);
    check({tag, "_rowfull_held"}, {7'd0, rf1}, {7'd0, rf_want});
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    clear_board();
    #12;
    check("rst_addr",       {24'd0, addr1}, 32'd0);
    check("rst_complete",   {31'd0, cp1},   32'd0);
    check("rst_row_full",   {7'd0, rf1},    32'd0);
    check("rst_full_count", {27'd0, fc1},   32'd0);
    check("rst_first_full", {27'd0, ff1},   32'd31);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);

    // 1: empty board
    run_sweep(lat1, lat3);
    check("t1_latency",   lat1, 32'd251);
    check("t1_row_full",  {7'd0, rf1},  32'd0);
    check("t1_full_count",{27'd0, fc1}, 32'd0);
    check("t1_first_full",{27'd0, ff1}, 32'd31);
    repeat (3) @(posedge clk);
    #1;
    check("t1_complete_held", {31'd0, cp1}, 32'd1);
    check("t1_done_addr",     {24'd0, addr1}, 32'd0);
    end_sweep("t1", 25'd0);

    // 2 and 6: rows 0, 7, 24 filled
    clear_board();
    fill_row(0, 6'h15);
    fill_row(7, 6'h15);
    fill_row(24, 6'h15);
    run_sweep(lat1, lat3);
    check("t2_latency",    lat1, 32'd251);
    check("t2_row_full",   {7'd0, rf1},  32'h1000081);
    check("t2_full_count", {27'd0, fc1}, 32'd3);
    check("t2_first_full", {27'd0, ff1}, 32'd0);
    check("t6_latency",    lat3, 32'd253);
    check("t6_row_full",   {7'd0, rf3},  32'h1000081);
    check("t6_full_count", {27'd0, fc3}, 32'd3);
    check("t6_first_full", {27'd0, ff3}, 32'd0);
    end_sweep("t2", 25'h1000081);

    // 3: row 12 missing its last cell, row 13 full
    clear_board();
    fill_row(12, 6'h3F);
    board[12*10 + 9] = 6'd0;
    for (int c = 0; c < 10; c++) board[13*10 + c] = 6'(c + 1);
    run_sweep(lat1, lat3);
    check("t3_row_full",   {7'd0, rf1},  32'h0002000);
    check("t3_full_count", {27'd0, fc1}, 32'd1);
    check("t3_first_full", {27'd0, ff1}, 32'd13);
    check("t3_rl3_row_full", {7'd0, rf3}, 32'h0002000);
    end_sweep("t3", 25'h0002000);

    // 4: abort at cycle 100, then a full sweep on the all-full board
    for (int r = 0; r < 25; r++) fill_row(r, (r % 2 == 0) ? 6'h01 : 6'h2A);
    seen = 0;
    @(negedge clk) enable = 1'b1;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (cp1 === 1'b1 || cp3 === 1'b1) seen++;
    end
    @(negedge clk) enable = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (cp1 === 1'b1 || cp3 === 1'b1) seen++;
    end
    check("t4_abort_complete", seen, 32'd0);
    check("t4_abort_addr", {24'd0, addr1}, 32'd0);
    run_sweep(lat1, lat3);
    check("t4_latency",    lat1, 32'd251);
    check("t4_row_full",   {7'd0, rf1},  32'h1FFFFFF);
    check("t4_full_count", {27'd0, fc1}, 32'd25);
    check("t4_first_full", {27'd0, ff1}, 32'd0);
    check("t4_rl3_full_count", {27'd0, fc3}, 32'd25);
    end_sweep("t4", 25'h1FFFFFF);

    // 5: asynchronous reset mid-sweep
    @(negedge clk) enable = 1'b1;
    repeat (60) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_row_full",   {7'd0, rf1},    32'd0);
    check("t5_full_count", {27'd0, fc1},   32'd0);
    check("t5_first_full", {27'd0, ff1},   32'd31);
    check("t5_complete",   {31'd0, cp1},   32'd0);
    check("t5_addr",       {24'd0, addr1}, 32'd0);
    @(negedge clk) enable = 1'b0;
    @(negedge clk) reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (cp1 === 1'b1 || cp3 === 1'b1) seen++;
    end
    check("t5_no_complete", seen, 32'd0);
    run_sweep(lat1, lat3);
    check("t5_latency",  lat1, 32'd251);
    check("t5_row_full", {7'd0, rf1}, 32'h1FFFFFF);
    end_sweep("t5", 25'h1FFFFFF);

    check("addr_sequence", addr_bad, 32'd0);
    check("wren_never_set", {31'd0, wren_seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
